// File: rtl/character_anim_ctrl.sv
// Fighter sprite animation sequencer: picks the animation strip and frame on each synchronised frame tick.
// The tick lands 3 Clk edges after a frame_clk rise; pulses last one Clk; no backpressure.
module character_anim_ctrl #(
  parameter int N_STAND         = 8,
  parameter int N_FWD           = 5,
  parameter int N_BWD           = 5,
  parameter int N_ATTACK        = 9,
  parameter int N_HURT          = 4,
  parameter int N_DEFEND        = 1,
  parameter int N_DIE           = 12,
  parameter int TICKS_PER_FRAME = 4,
  parameter int HIT_FRAME       = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] game_state,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_attack,
  input  logic       key_defend,
  input  logic       hurt_hit,
  input  logic       die,
  output logic [7:0] character_state,
  output logic [7:0] frame_num,
  output logic       move_l,
  output logic       move_r,
  output logic       attack_active,
  output logic       anim_done
);

  localparam logic [2:0] ST_STAND  = 3'd0;
  localparam logic [2:0] ST_ATTACK = 3'd1;
  localparam logic [2:0] ST_MOVEL  = 3'd2;
  localparam logic [2:0] ST_MOVER  = 3'd3;
  localparam logic [2:0] ST_HURT   = 3'd4;
  localparam logic [2:0] ST_DEFEND = 3'd5;
  localparam logic [2:0] ST_DIE    = 3'd6;

  localparam logic [7:0] SUB_MAX = 8'(TICKS_PER_FRAME - 1);
  localparam logic [7:0] HIT_IDX = 8'(HIT_FRAME);

  logic [2:0] state, state_nx, want;
  logic [7:0] frame, frame_nx, sub, sub_nx, last_frame;
  logic       sync1, sync2, sync3, hurt_d, hurt_pending;
  logic       tick, hurt_rise, hurt_now, sub_wrap, done_nx;

  assign tick      = sync2 & ~sync3;
  assign hurt_rise = hurt_hit & ~hurt_d;
  // a hurt edge arriving on the tick cycle itself still counts for that tick
  assign hurt_now  = hurt_pending | hurt_rise;
  assign sub_wrap  = (sub == SUB_MAX);

  always_comb begin
    case (state)
      ST_ATTACK: last_frame = 8'(N_ATTACK - 1);
      ST_MOVEL:  last_frame = 8'(N_BWD - 1);
      ST_MOVER:  last_frame = 8'(N_FWD - 1);
      ST_HURT:   last_frame = 8'(N_HURT - 1);
      ST_DEFEND: last_frame = 8'(N_DEFEND - 1);
      ST_DIE:    last_frame = 8'(N_DIE - 1);
      default:   last_frame = 8'(N_STAND - 1);
    endcase
  end

  always_comb begin
    if (key_attack)                  want = ST_ATTACK;
    else if (key_defend)             want = ST_DEFEND;
    else if (key_right && !key_left) want = ST_MOVER;
    else if (key_left && !key_right) want = ST_MOVEL;
    else                             want = ST_STAND;
  end

  always_comb begin
    state_nx = state;
    frame_nx = frame;
    sub_nx   = sub;
    done_nx  = 1'b0;
    if (game_state == 8'd0) begin
      state_nx = ST_STAND;
      frame_nx = 8'd0;
      sub_nx   = 8'd0;
    end else if (game_state == 8'd1) begin
      sub_nx = sub_wrap ? 8'd0 : sub + 8'd1;
      if (sub_wrap)
        frame_nx = (frame == last_frame) ? 8'd0 : frame + 8'd1;
      if (state == ST_DIE) begin
        if (sub_wrap && frame == last_frame)
          frame_nx = frame;
      end else if (die) begin
        state_nx = ST_DIE;
        frame_nx = 8'd0;
        sub_nx   = 8'd0;
      end else if (hurt_now && state != ST_DEFEND) begin
        state_nx = ST_HURT;
        frame_nx = 8'd0;
        sub_nx   = 8'd0;
      end else if (hurt_now) begin
        // blocked hit: defend keeps running, keys are not re-evaluated this tick
        state_nx = state;
      end else if (state == ST_ATTACK || state == ST_HURT) begin
        if (sub_wrap && frame == last_frame) begin
          state_nx = ST_STAND;
          frame_nx = 8'd0;
          sub_nx   = 8'd0;
          done_nx  = 1'b1;
        end
      end else if (want != state) begin
        state_nx = want;
        frame_nx = 8'd0;
        sub_nx   = 8'd0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= ST_STAND;
      frame        <= 8'd0;
      sub          <= 8'd0;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      hurt_d       <= 1'b0;
      hurt_pending <= 1'b0;
      move_l       <= 1'b0;
      move_r       <= 1'b0;
      anim_done    <= 1'b0;
    end else begin
      sync1  <= frame_clk;
      sync2  <= sync1;
      sync3  <= sync2;
      hurt_d <= hurt_hit;
      if (tick) begin
        state        <= state_nx;
        frame        <= frame_nx;
        sub          <= sub_nx;
        hurt_pending <= 1'b0;
        move_l       <= (game_state == 8'd1) && (state_nx == ST_MOVEL);
        move_r       <= (game_state == 8'd1) && (state_nx == ST_MOVER);
        anim_done    <= done_nx;
      end else begin
        move_l    <= 1'b0;
        move_r    <= 1'b0;
        anim_done <= 1'b0;
        if (game_state == 8'd0)
          hurt_pending <= 1'b0;
        else if (hurt_rise)
          hurt_pending <= 1'b1;
      end
    end
  end

  assign character_state = {5'd0, state};
  assign frame_num       = frame;
  assign attack_active   = (game_state == 8'd1) && (state == ST_ATTACK) && (frame == HIT_IDX);

endmodule

// File: tb/tb_character_anim_ctrl.sv
// Bench for character_anim_ctrl: directed scenarios plus random play checked against a tick-count model.
module tb_character_anim_ctrl;

  localparam int TPF = 4;
  localparam int HIT = 4;
  localparam int S_STAND = 0, S_ATTACK = 1, S_MOVEL = 2, S_MOVER = 3, S_HURT = 4, S_DEFEND = 5, S_DIE = 6;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, key_left, key_right, key_attack, key_defend, hurt_hit, die;
  logic [7:0] game_state;
  logic [7:0] character_state, frame_num;
  logic       move_l, move_r, attack_active, anim_done;

  int checks = 0;
  int errors = 0;

  // model: state plus number of ticks spent in it since entry
  int m_st, m_t;
  bit m_pend, e_ml, e_mr, e_done;

  logic [7:0] o_state, o_frame;
  logic       o_ml, o_mr, o_att, o_done, l_pulse;

  character_anim_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_state(game_state),
    .key_left(key_left), .key_right(key_right), .key_attack(key_attack), .key_defend(key_defend),
    .hurt_hit(hurt_hit), .die(die), .character_state(character_state), .frame_num(frame_num),
    .move_l(move_l), .move_r(move_r), .attack_active(attack_active), .anim_done(anim_done)
  );

  always #10 Clk = ~Clk;

  function automatic int n_of(int s);
    case (s)
      S_STAND:  return 8;
      S_ATTACK: return 9;
      S_MOVEL:  return 5;
      S_MOVER:  return 5;
      S_HURT:   return 4;
      S_DEFEND: return 1;
      default:  return 12;
    endcase
  endfunction

  function automatic int exp_frame();
    if (m_st == S_DIE) return (m_t / TPF > 11) ? 11 : m_t / TPF;
    if (m_st == S_ATTACK || m_st == S_HURT) return m_t / TPF;
    return (m_t / TPF) % n_of(m_st);
  endfunction

  task automatic enter(input int s);
    m_st = s;
    m_t  = 0;
  endtask

  task automatic model_step();
    int want;
    e_done = 0;
    if (game_state == 8'd0) begin
      enter(S_STAND);
    end else if (game_state == 8'd1) begin
      if (key_attack)                  want = S_ATTACK;
      else if (key_defend)             want = S_DEFEND;
      else if (key_right && !key_left) want = S_MOVER;
      else if (key_left && !key_right) want = S_MOVEL;
      else                             want = S_STAND;
      if (m_st == S_DIE) m_t++;
      else if (die) enter(S_DIE);
      else if (m_pend && m_st != S_DEFEND) enter(S_HURT);
      else if (m_pend) m_t++;
      else if (m_st == S_ATTACK || m_st == S_HURT) begin
        if (m_t + 1 >= n_of(m_st) * TPF) begin
          enter(S_STAND);
          e_done = 1;
        end else m_t++;
      end else if (want == m_st) m_t++;
      else enter(want);
    end
    m_pend = 0;
    e_ml = (game_state == 8'd1) && (m_st == S_MOVEL);
    e_mr = (game_state == 8'd1) && (m_st == S_MOVER);
  endtask

  task automatic do_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    model_step();
    #1;
    o_state = character_state;
    o_frame = frame_num;
    o_ml    = move_l;
    o_mr    = move_r;
    o_att   = attack_active;
    o_done  = anim_done;
    @(posedge Clk);
    #1;
    l_pulse = move_l | move_r | anim_done;
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
  endtask

  task automatic pulse_hurt();
    @(negedge Clk);
    hurt_hit = 1'b1;
    @(negedge Clk);
    hurt_hit = 1'b0;
    if (game_state != 8'd0) m_pend = 1;
  endtask

  task automatic clear_keys();
    key_left = 0; key_right = 0; key_attack = 0; key_defend = 0; die = 0;
  endtask

  task automatic go_stand();
    @(negedge Clk);
    clear_keys();
    game_state = 8'd0;
    do_tick();
    game_state = 8'd1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (character_state !== 8'd0) begin errors++; $display("FAIL reset_state got %0d want 0", character_state); end
    checks++; if (frame_num !== 8'd0) begin errors++; $display("FAIL reset_frame got %0d want 0", frame_num); end
    checks++; if ({move_l, move_r, attack_active, anim_done} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got %b want 0000", {move_l, move_r, attack_active, anim_done}); end
    @(negedge Clk);
    Reset = 1'b1;
    m_st = S_STAND; m_t = 0; m_pend = 0;
  endtask

  task automatic test_move_right();
    int frames [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int nr = 0, nl = 0, late = 0;
    go_stand();
    key_right = 1;
    for (int i = 0; i < 8; i++) begin
      do_tick();
      checks++; if (o_state !== 8'd3) begin errors++; $display("FAIL mover_state tick %0d got %0d want 3", i, o_state); end
      checks++; if (o_frame !== 8'(frames[i])) begin errors++; $display("FAIL mover_frame tick %0d got %0d want %0d", i, o_frame, frames[i]); end
      nr += int'(o_mr); nl += int'(o_ml); late += int'(l_pulse);
    end
    checks++; if (nr != 8) begin errors++; $display("FAIL mover_pulses got %0d want 8", nr); end
    checks++; if (nl != 0) begin errors++; $display("FAIL mover_left_pulses got %0d want 0", nl); end
    checks++; if (late != 0) begin errors++; $display("FAIL pulse_width got %0d long pulses want 0", late); end
  endtask

  task automatic test_attack();
    int n_att = 1, n_act = 0, n_done = 0;
    go_stand();
    key_attack = 1;
    do_tick();
    key_attack = 0;
    checks++; if (o_state !== 8'd1) begin errors++; $display("FAIL attack_entry got %0d want 1", o_state); end
    for (int i = 0; i < 50; i++) begin
      do_tick();
      n_done += int'(o_done);
      if (o_state != 8'd1) break;
      n_att++;
      if (o_att) n_act++;
      checks++; if (o_att !== ((n_att - 1) / TPF == HIT)) begin
        errors++; $display("FAIL attack_active at tick %0d got %b frame %0d", n_att, o_att, o_frame); end
    end
    checks++; if (n_att != 36) begin errors++; $display("FAIL attack_length got %0d want 36", n_att); end
    checks++; if (n_act != 4) begin errors++; $display("FAIL attack_hit_ticks got %0d want 4", n_act); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL attack_done got %0d want 1", n_done); end
    checks++; if (o_state !== 8'd0) begin errors++; $display("FAIL attack_exit got %0d want 0", o_state); end
  endtask

  task automatic test_defend_hurt();
    go_stand();
    key_defend = 1;
    do_tick();
    pulse_hurt();
    do_tick();
    checks++; if (o_state !== 8'd5) begin errors++; $display("FAIL defend_block got %0d want 5", o_state); end
    key_defend = 0;
    do_tick();
    checks++; if (o_state !== 8'd0) begin errors++; $display("FAIL defend_pending_cleared got %0d want 0", o_state); end
  endtask

  task automatic test_die();
    int bad = 0;
    go_stand();
    key_attack = 1;
    do_tick();
    key_attack = 0;
    repeat (5) do_tick();
    pulse_hurt();
    die = 1;
    do_tick();
    checks++; if (o_state !== 8'd6 || o_frame !== 8'd0) begin
      errors++; $display("FAIL die_entry got state %0d frame %0d want 6/0", o_state, o_frame); end
    for (int k = 1; k < 148; k++) begin
      do_tick();
      if (o_state !== 8'd6 || o_frame !== 8'((k / TPF > 11) ? 11 : k / TPF)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL die_climb_hold got %0d bad ticks want 0", bad); end
    checks++; if (o_frame !== 8'd11) begin errors++; $display("FAIL die_final_frame got %0d want 11", o_frame); end
    die = 0;
    game_state = 8'd0;
    do_tick();
    checks++; if (o_state !== 8'd0 || o_frame !== 8'd0) begin
      errors++; $display("FAIL die_exit got state %0d frame %0d want 0/0", o_state, o_frame); end
  endtask

  task automatic test_reset_mid_hurt();
    go_stand();
    pulse_hurt();
    repeat (9) do_tick();
    checks++; if (o_state !== 8'd4 || o_frame !== 8'd2) begin
      errors++; $display("FAIL hurt_frame2 got state %0d frame %0d want 4/2", o_state, o_frame); end
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    checks++; if ({character_state, frame_num, move_l, move_r, attack_active, anim_done} !== 20'd0) begin
      errors++; $display("FAIL midreset_outputs got state %0d frame %0d", character_state, frame_num); end
    @(negedge Clk);
    Reset = 1'b1;
    m_st = S_STAND; m_t = 0; m_pend = 0;
    do_tick();
    checks++; if (o_state !== 8'd0 || o_frame !== 8'd0) begin
      errors++; $display("FAIL post_reset_tick got state %0d frame %0d want 0/0", o_state, o_frame); end
  endtask

  task automatic test_gameover_freeze();
    int bad = 0;
    go_stand();
    key_right = 1;
    repeat (13) do_tick();
    checks++; if (o_state !== 8'd3 || o_frame !== 8'd3) begin
      errors++; $display("FAIL mover_frame3 got state %0d frame %0d want 3/3", o_state, o_frame); end
    game_state = 8'd2;
    repeat (6) begin
      do_tick();
      if (o_state !== 8'd3 || o_frame !== 8'd3 || o_mr !== 1'b0 || o_ml !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL gameover_freeze got %0d bad ticks want 0", bad); end
    game_state = 8'd0;
    do_tick();
    checks++; if (o_state !== 8'd0 || o_frame !== 8'd0) begin
      errors++; $display("FAIL start_forces_stand got state %0d frame %0d want 0/0", o_state, o_frame); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      r = int'($urandom_range(0, 99));
      game_state = (r < 4) ? 8'd0 : (r < 9) ? 8'd2 : 8'd1;
      if (m_st == S_DIE && $urandom_range(0, 5) == 0) game_state = 8'd0;
      key_left   = ($urandom_range(0, 1) == 1);
      key_right  = ($urandom_range(0, 1) == 1);
      key_attack = ($urandom_range(0, 7) == 0);
      key_defend = ($urandom_range(0, 5) == 0);
      die        = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) == 0) pulse_hurt();
      do_tick();
      checks++; if (o_state !== 8'(m_st) || o_frame !== 8'(exp_frame())) begin
        errors++; $display("FAIL rand_state it %0d got %0d/%0d want %0d/%0d", i, o_state, o_frame, m_st, exp_frame()); end
      checks++; if ({o_ml, o_mr, o_done} !== {e_ml, e_mr, e_done}) begin
        errors++; $display("FAIL rand_pulses it %0d got %b want %b", i, {o_ml, o_mr, o_done}, {e_ml, e_mr, e_done}); end
      checks++; if (o_att !== (game_state == 8'd1 && m_st == S_ATTACK && exp_frame() == HIT)) begin
        errors++; $display("FAIL rand_attack_active it %0d got %b", i, o_att); end
      checks++; if (int'(o_frame) >= n_of(int'(o_state))) begin
        errors++; $display("FAIL rand_frame_bound it %0d frame %0d state %0d", i, o_frame, o_state); end
    end
  endtask

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; game_state = 8'd0; hurt_hit = 1'b0;
    clear_keys();
    m_st = S_STAND; m_t = 0; m_pend = 0;
    test_reset();
    test_move_right();
    test_attack();
    test_defend_hurt();
    test_die();
    test_reset_mid_hurt();
    test_gameover_freeze();
    go_stand();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/character_anim_ctrl.md
CHARACTER_ANIM_CTRL -- requirements
Module: character_anim_ctrl

Interface
REQ-001 Parameters SHALL be, each as name, default, meaning:
- N_STAND, 8, frames in the stand strip.
- N_FWD, 5, frames in the move-right strip.
- N_BWD, 5, frames in the move-left strip.
- N_ATTACK, 9, frames in the attack strip.
- N_HURT, 4, frames in the hurt strip.
- N_DEFEND, 1, frames in the defend strip.
- N_DIE, 12, frames in the KO strip.
- TICKS_PER_FRAME, 4, frame ticks per animation frame.
- HIT_FRAME, 4, attack frame on which the hitbox is active.
REQ-002 Ports SHALL be, each as name, direction, width, meaning:
- Clk, in, 1, 50 MHz system clock; the only clock.
- Reset, in, 1, synchronous, active-low reset.
- frame_clk, in, 1, ~60 Hz frame strobe from the VGA controller.
- game_state, in, 8, game phase: 0 start, 1 game, 2 gameover.
- key_left, in, 1, move-left request.
- key_right, in, 1, move-right request.
- key_attack, in, 1, attack request.
- key_defend, in, 1, defend request.
- hurt_hit, in, 1, hit received (level).
- die, in, 1, HP exhausted (level).
- character_state, out, 8, animation state: stand 0, attack 1, movel 2, mover 3, hurt 4, defend 5, die 6.
- frame_num, out, 8, index of the current frame within the strip.
- move_l, out, 1, one-Clk pulse per frame tick while in movel.
- move_r, out, 1, one-Clk pulse per frame tick while in mover.
- attack_active, out, 1, hitbox active.
- anim_done, out, 1, one-Clk pulse when an attack or hurt strip completes.

Function
REQ-003 frame_clk SHALL be synchronised through two flops; a rising edge SHALL produce a one-Clk tick pulse 3 Clk cycles after the rising edge.
REQ-004 State, frame_num, the sub-tick counter and all output pulses SHALL update only on the Clk edge where tick=1, except the hurt_pending capture described in REQ-011.
REQ-005 A sub-tick counter SHALL count 0 to TICKS_PER_FRAME-1. frame_num SHALL advance when the counter wraps.
REQ-006 In stand, movel and mover, frame_num SHALL wrap from N_x-1 to 0.
REQ-007 Each state change SHALL set frame_num=0 and the sub-tick counter=0.
REQ-008 When game_state==1, the next state at a tick SHALL be chosen by this priority: die, then pending hurt, then attack, then defend, then movement, then stand.
- die=1 -> die.
- hurt_pending=1 and state is not defend -> hurt.
- Attack and hurt SHALL NOT be interruptible except by die or a new hurt.
- key_attack -> attack.
- key_defend -> defend.
- key_right and not key_left -> mover.
- key_left and not key_right -> movel.
- key_left and key_right together -> stand.
REQ-009 Attack SHALL run frames 0..N_ATTACK-1 once, then pulse anim_done and return to stand; hurt SHALL do the same over its own frames.
REQ-010 A hurt during hurt SHALL restart at frame 0.
REQ-011 hurt_hit handling:
- A rising edge of hurt_hit, detected on any Clk, SHALL set hurt_pending.
- hurt_pending SHALL clear at the next tick.
- hurt_pending set while in defend SHALL be discarded, with no state change.
REQ-012 die SHALL run frames 0..N_DIE-1 and then hold frame N_DIE-1. The die state SHALL be left only by reset or by a game_state transition into 0.
REQ-013 attack_active SHALL be 1 exactly while state==attack and frame_num==HIT_FRAME.
REQ-014 move_r and move_l SHALL pulse on the tick Clk cycle while in mover or movel respectively, and never both at once.
REQ-015 game_state effects:
- game_state==0 SHALL force stand with frame_num and the sub-tick counter held at 0, and clear hurt_pending.
- game_state==2 SHALL freeze the state and frame_num, with all pulses and attack_active at 0.
REQ-016 frame_num SHALL never reach or exceed the N_x of the current state.

Reset
REQ-017 While Reset=0 on a Clk edge, the block SHALL set: character_state=0, frame_num=0, sub-tick=0, hurt_pending=0, synchroniser flops=0, move_l=0, move_r=0, attack_active=0, anim_done=0.
REQ-018 Reset mid-animation SHALL abort it; the first tick after release SHALL evaluate REQ-008 from stand.

Verification
REQ-019 game_state=1, key_right held, 8 ticks -> state 3, frame_num 0,0,0,0,1,1,1,1; move_r exactly 8 pulses; move_l 0.
REQ-020 key_attack for one tick, then released -> attack for 36 ticks; attack_active high during the 4 ticks where frame_num=4; anim_done pulse; then state 0.
REQ-021 In defend, hurt_hit pulse -> state stays 5; hurt_pending cleared at the next tick.
REQ-022 Mid-attack, hurt_hit and die asserted in the same tick -> state 6; then frame_num climbs to 11 and holds through 100 further ticks.
REQ-023 In hurt frame 2, Reset=0 for one Clk -> all outputs 0; next tick with no keys -> state 0, frame_num 0.
REQ-024 game_state 1->2 during mover frame 3 -> state 3 and frame 3 frozen, move_r 0; then game_state=0 -> state 0, frame 0.
